// File: rtl/riscv_define.sv
// Shared constants for the RISC-V pipeline control slice: stage indices of
// the classic 5-stage pipeline and default hazard-controller parameters.
package riscv_define;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_STAGES  = 5;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_TO_W    = 10;
  localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/riscv_prio_msb.sv
// Highest-set-bit encoder: returns the index of the most significant set bit
// of vec_i and whether any bit was set at all.
module riscv_prio_msb #(
  parameter int W  = 5,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    idx_o = {IW{1'b0}};
    vld_o = |vec_i;
    for (int i = 0; i < W; i++) begin
      idx_o = vec_i[i] ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline hazard controller: resolves stall and flush requests from all
// stages into per-stage hold/bubble enables, defers flushes whose source stage
// is itself held, and tracks stall duration (watchdog) and stall occupancy.
module riscv_pipe_ctrl
  import riscv_define::*;
#(
  parameter int STAGES  = DEF_STAGES,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] req_stall,
  input  logic [STAGES-1:0] req_flush,
  input  logic              wd_clear,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Resolved request indices
  logic [IW-1:0] k_s;
  logic          k_vld_s;
  logic [IW-1:0] f_s;
  logic          f_vld_s;

  // Decoded vectors
  logic [STAGES-1:0] stall_s;
  logic [STAGES-1:0] bubble_s;
  logic [STAGES-1:0] mask_s;
  logic [STAGES-1:0] flush_s;
  logic              apply_s;
  logic              defer_s;
  logic              release_s;

  // Deferred flush state: pending mask and the highest stage that produced it
  logic [STAGES-1:0] pend_q, pend_d;
  logic [IW-1:0]     src_q, src_d;

  // Watchdog and performance counter state
  logic [TO_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  riscv_prio_msb #(.W(STAGES), .IW(IW)) u_stall_msb (
    .vec_i (req_stall),
    .idx_o (k_s),
    .vld_o (k_vld_s)
  );

  riscv_prio_msb #(.W(STAGES), .IW(IW)) u_flush_msb (
    .vec_i (req_flush),
    .idx_o (f_s),
    .vld_o (f_vld_s)
  );

  // Expand the oldest stalled stage and redirecting stage into per-stage vectors.
  always_comb begin
    stall_s  = {STAGES{1'b0}};
    bubble_s = {STAGES{1'b0}};
    mask_s   = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      stall_s[i]  = k_vld_s && (i <= int'(k_s));
      bubble_s[i] = k_vld_s && (i == int'(k_s) + 1);
      mask_s[i]   = f_vld_s && (i < int'(f_s));
    end
  end

  // Decide whether a redirect kills now, is deferred, or a pending kill releases.
  always_comb begin
    apply_s   = f_vld_s && (!k_vld_s || (k_s < f_s));
    defer_s   = f_vld_s && (f_s != IW'(STG_IF)) && k_vld_s && (k_s >= f_s);
    release_s = (|pend_q) && (!k_vld_s || (k_s < src_q));
    // Held stages are never killed; the bubble below the stall always enters.
    flush_s   = (((apply_s ? mask_s : {STAGES{1'b0}}) |
                  (release_s ? pend_q : {STAGES{1'b0}})) & ~stall_s) | bubble_s;
  end

  // Next state of the deferred-flush register (release and new defer can coincide).
  always_comb begin
    pend_d = (release_s ? {STAGES{1'b0}} : pend_q) | (defer_s ? mask_s : {STAGES{1'b0}});
    if (defer_s) begin
      if (release_s || (f_s > src_q)) begin
        src_d = f_s;
      end else begin
        src_d = src_q;
      end
    end else if (release_s) begin
      src_d = {IW{1'b0}};
    end else begin
      src_d = src_q;
    end
  end

  // Next state of watchdog counter, sticky timeout flag and stall-cycle counter.
  always_comb begin
    if (wd_clear || !k_vld_s) begin
      wd_cnt_d = {TO_W{1'b0}};
    end else if (wd_cnt_q >= TO_LIM) begin
      wd_cnt_d = wd_cnt_q;
    end else begin
      wd_cnt_d = wd_cnt_q + TO_ONE;
    end

    if (wd_clear) begin
      timeout_d = 1'b0;
    end else if (wd_cnt_q >= TO_LIM) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end

    if (k_vld_s && (cycles_q != CNT_MAX)) begin
      cycles_d = cycles_q + CNT_ONE;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Deferred-flush register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= {STAGES{1'b0}};
      src_q  <= {IW{1'b0}};
    end else begin
      pend_q <= pend_d;
      src_q  <= src_d;
    end
  end

  // Watchdog and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= {TO_W{1'b0}};
      timeout_q <= 1'b0;
      cycles_q  <= {CNT_W{1'b0}};
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  // Same-cycle enables are silenced while reset is asserted.
  always_comb begin
    if (rst_n) begin
      stall = stall_s;
      flush = flush_s;
    end else begin
      stall = {STAGES{1'b0}};
      flush = {STAGES{1'b0}};
    end
    stall_timeout = timeout_q;
    stall_cycles  = cycles_q;
  end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench for riscv_pipe_ctrl with a 5-stage pipe, a short watchdog
// (TIMEOUT=4) and a 3-bit stall counter so saturation is reachable quickly.
module tb_riscv_pipe_ctrl;

  localparam int STAGES  = 5;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [STAGES-1:0] req_stall = 5'b00000;
  logic [STAGES-1:0] req_flush = 5'b00000;
  logic              wd_clear = 1'b0;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_pipe_ctrl #(
    .STAGES  (STAGES),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_stall     (req_stall),
    .req_flush     (req_flush),
    .wd_clear      (wd_clear),
    .stall         (stall),
    .flush         (flush),
    .stall_timeout (stall_timeout),
    .stall_cycles  (stall_cycles)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_stall = 5'b00000;
    req_flush = 5'b00000;
    wd_clear  = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_stall = 5'b01000;
    #1;
    vectors++;
    if (stall !== 5'b00000 || flush !== 5'b00000 || stall_cycles !== 3'd0 || stall_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: stall=%b flush=%b cycles=%0d timeout=%b, expected all zero",
               stall, flush, stall_cycles, stall_timeout);
    end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (stall !== 5'b01111 || flush !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_mem_stall: stall=%b flush=%b, expected 01111/10000", stall, flush);
    end
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if (stall_cycles !== 3'(n)) begin
        miscompares++;
        $display("FAIL reset_pre_count: cycles=%0d expected %0d", stall_cycles, n);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (stall !== 5'b00000 || flush !== 5'b00000 || stall_cycles !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_async: stall=%b flush=%b cycles=%0d, expected 0/0/0",
               stall, flush, stall_cycles);
    end
    req_stall = 5'b00000;
  endtask

  task automatic test_single_stall;
    do_reset();
    req_stall = 5'b00100;
    #1;
    vectors++;
    if (stall !== 5'b00111 || flush !== 5'b01000 || stall_cycles !== 3'd0) begin
      miscompares++;
      $display("FAIL single_stall: stall=%b flush=%b cycles=%0d, expected 00111/01000/0",
               stall, flush, stall_cycles);
    end
    for (int n = 1; n <= 3; n++) begin
      tick();
      vectors++;
      if (stall_cycles !== 3'(n) || stall !== 5'b00111) begin
        miscompares++;
        $display("FAIL single_count: cycles=%0d stall=%b, expected %0d/00111", stall_cycles, stall, n);
      end
    end
    req_stall = 5'b00000;
    tick();
    vectors++;
    if (stall_cycles !== 3'd3 || stall !== 5'b00000 || flush !== 5'b00000) begin
      miscompares++;
      $display("FAIL single_idle: cycles=%0d stall=%b flush=%b, expected 3/00000/00000",
               stall_cycles, stall, flush);
    end
  endtask

  task automatic test_deferred_flush;
    do_reset();
    // EX redirect while MEM is held: only the bubble into WB, mask 00011 deferred
    req_stall = 5'b01000;
    req_flush = 5'b00100;
    #1;
    vectors++;
    if (stall !== 5'b01111 || flush !== 5'b10000) begin
      miscompares++;
      $display("FAIL defer_latch: stall=%b flush=%b, expected 01111/10000", stall, flush);
    end
    tick();
    req_flush = 5'b00000;
    #1;
    vectors++;
    if (flush !== 5'b10000) begin
      miscompares++;
      $display("FAIL defer_hold: flush=%b expected 10000", flush);
    end
    tick();
    req_stall = 5'b00000;
    #1;
    vectors++;
    if (flush !== 5'b00011 || stall !== 5'b00000) begin
      miscompares++;
      $display("FAIL defer_release: flush=%b stall=%b, expected 00011/00000", flush, stall);
    end
    tick();
    vectors++;
    if (flush !== 5'b00000) begin
      miscompares++;
      $display("FAIL defer_cleared: flush=%b expected 00000", flush);
    end
    // Stall exactly at the redirecting stage also defers
    req_stall = 5'b00100;
    req_flush = 5'b00100;
    #1;
    vectors++;
    if (flush !== 5'b01000 || stall !== 5'b00111) begin
      miscompares++;
      $display("FAIL defer_equal: flush=%b stall=%b, expected 01000/00111", flush, stall);
    end
    tick();
    req_stall = 5'b00000;
    req_flush = 5'b00000;
    #1;
    vectors++;
    if (flush !== 5'b00011) begin
      miscompares++;
      $display("FAIL defer_equal_release: flush=%b expected 00011", flush);
    end
    tick();
    // WB held: no bubble; two deferred redirects merge into 00111
    req_stall = 5'b10000;
    req_flush = 5'b00100;
    #1;
    vectors++;
    if (flush !== 5'b00000 || stall !== 5'b11111) begin
      miscompares++;
      $display("FAIL defer_wb_stall: flush=%b stall=%b, expected 00000/11111", flush, stall);
    end
    tick();
    req_flush = 5'b01000;
    #1;
    vectors++;
    if (flush !== 5'b00000) begin
      miscompares++;
      $display("FAIL defer_merge_hold: flush=%b expected 00000", flush);
    end
    tick();
    req_stall = 5'b00000;
    req_flush = 5'b00000;
    #1;
    vectors++;
    if (flush !== 5'b00111) begin
      miscompares++;
      $display("FAIL defer_merge_release: flush=%b expected 00111", flush);
    end
    tick();
    vectors++;
    if (flush !== 5'b00000) begin
      miscompares++;
      $display("FAIL defer_merge_cleared: flush=%b expected 00000", flush);
    end
  endtask

  task automatic test_flush_younger;
    logic [STAGES-1:0] rf [4];
    logic [STAGES-1:0] rs [4];
    logic [STAGES-1:0] es [4];
    logic [STAGES-1:0] ef [4];
    do_reset();
    rf[0] = 5'b01000; rs[0] = 5'b00010; es[0] = 5'b00011; ef[0] = 5'b00100;
    rf[1] = 5'b10000; rs[1] = 5'b00000; es[1] = 5'b00000; ef[1] = 5'b01111;
    rf[2] = 5'b00001; rs[2] = 5'b00000; es[2] = 5'b00000; ef[2] = 5'b00000;
    rf[3] = 5'b00110; rs[3] = 5'b00000; es[3] = 5'b00000; ef[3] = 5'b00011;
    for (int v = 0; v < 4; v++) begin
      req_flush = rf[v];
      req_stall = rs[v];
      #1;
      vectors++;
      if (stall !== es[v] || flush !== ef[v]) begin
        miscompares++;
        $display("FAIL flush_young[%0d]: stall=%b flush=%b, expected %b/%b",
                 v, stall, flush, es[v], ef[v]);
      end
      tick();
    end
    req_flush = 5'b00000;
    req_stall = 5'b00000;
    #1;
    vectors++;
    if (flush !== 5'b00000) begin
      miscompares++;
      $display("FAIL flush_young_none_pending: flush=%b expected 00000", flush);
    end
  endtask

  task automatic test_watchdog;
    do_reset();
    req_stall = 5'b00001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (stall_timeout !== (e >= 5)) begin
        miscompares++;
        $display("FAIL wd_fire edge %0d: timeout=%b expected %b", e, stall_timeout, (e >= 5));
      end
    end
    wd_clear = 1'b1;
    tick();
    wd_clear = 1'b0;
    vectors++;
    if (stall_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_clear: timeout=%b expected 0", stall_timeout);
    end
    // Counter must restart from zero: four more stalled edges, no flag yet
    for (int e = 1; e <= 4; e++) begin
      tick();
      vectors++;
      if (stall_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_restart edge %0d: timeout=%b expected 0", e, stall_timeout);
      end
    end
    // Flag would set on this edge; the clear wins
    wd_clear = 1'b1;
    tick();
    wd_clear = 1'b0;
    vectors++;
    if (stall_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_clear_wins: timeout=%b expected 0", stall_timeout);
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      vectors++;
      if (stall_timeout !== (e == 5)) begin
        miscompares++;
        $display("FAIL wd_refire edge %0d: timeout=%b expected %b", e, stall_timeout, (e == 5));
      end
    end
    req_stall = 5'b00000;
  endtask

  task automatic test_counter_sat;
    do_reset();
    req_stall = 5'b00001;
    for (int n = 1; n <= 10; n++) begin
      tick();
      vectors++;
      if (stall_cycles !== 3'((n > 7) ? 7 : n)) begin
        miscompares++;
        $display("FAIL cnt_sat edge %0d: cycles=%0d expected %0d", n, stall_cycles, (n > 7) ? 7 : n);
      end
    end
    req_stall = 5'b00000;
    tick();
    vectors++;
    if (stall_cycles !== 3'd7) begin
      miscompares++;
      $display("FAIL cnt_hold: cycles=%0d expected 7", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_single_stall();
    test_deferred_flush();
    test_flush_younger();
    test_watchdog();
    test_counter_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
